// File: rtl/commit_sequencer.sv
// In-order commit sequencer: records issuing unit IDs in a circular table and grants register-file
// writes strictly in issue order. Define COMMIT_SEQ_FAST_EN for the combinational 1-commit/cycle grant.
module commit_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [2:0] issue_unit,
    output logic       issue_ready,
    input  logic [4:0] unit_done,
    output logic [4:0] commit_grant,
    input  logic       flush,
    output logic [4:0] occupancy,
    output logic       err_illegal
);

    localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);

    logic [2:0]       r_entry [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [4:0]       r_count;
    logic             r_err;

    logic [4:0]       w_count_next;
    logic [2:0]       w_head;
    logic [4:0]       w_head_oh;
    logic             w_head_done;
    logic             w_legal;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_wr_en;

    assign w_head      = r_entry[r_rd_ptr];
    assign w_head_oh   = 5'b00001 << w_head;
    // Only the head's done bit matters; results of younger units wait their turn.
    assign w_head_done = (r_count != 5'd0) && (|(w_head_oh & unit_done));
    assign issue_ready = (r_count != FULL_CNT);
    assign w_legal     = (issue_unit <= 3'd4);
    assign w_push      = issue_valid && issue_ready && w_legal && !flush;
    assign w_pop       = |commit_grant;
    assign occupancy   = r_count;
    assign err_illegal = r_err;

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = 5'd0;
        end else begin
            w_count_next = r_count + {4'd0, w_push} - {4'd0, w_pop};
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
        assign w_wr_en[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en[i]) begin
                    r_entry[i] <= issue_unit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            r_count <= w_count_next;
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Sticky: an illegal ID is reported even when flushed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (issue_valid && issue_ready && !w_legal) begin
            r_err <= 1'b1;
        end
    end

`ifdef COMMIT_SEQ_FAST_EN
    assign commit_grant = (w_head_done && !flush) ? w_head_oh : 5'd0;
`else
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t     r_state;
    logic [4:0] r_grant;

    // Flush kills a grant that is already registered for this cycle.
    assign commit_grant = flush ? 5'd0 : r_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_grant <= 5'd0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_grant <= 5'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_grant <= 5'd0;
                    if (w_push) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_head_done) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_head_oh;
                    end else begin
                        r_grant <= 5'd0;
                    end
                end
                ST_GRANT: begin
                    r_grant <= 5'd0;
                    r_state <= (w_count_next == 5'd0) ? ST_EMPTY : ST_WAIT;
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_grant <= 5'd0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Bench for commit_sequencer: directed table, corner-case sequences and random traffic
// checked every cycle against a queue-based model of the commit ordering rules.
module tb_commit_sequencer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [2:0] issue_unit = 3'd0;
    logic       issue_ready;
    logic [4:0] unit_done = 5'd0;
    logic [4:0] commit_grant;
    logic       flush = 1'b0;
    logic [4:0] occupancy;
    logic       err_illegal;

    commit_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_unit   (issue_unit),
        .issue_ready  (issue_ready),
        .unit_done    (unit_done),
        .commit_grant (commit_grant),
        .flush        (flush),
        .occupancy    (occupancy),
        .err_illegal  (err_illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queue of outstanding unit IDs, sticky error, and (registered
    // mode) whether the head was seen done in the previous non-grant, non-flush cycle.
    int   q[$];
    bit   m_err  = 1'b0;
    bit   m_elig = 1'b0;

    logic [4:0] obs_grant;
    logic [4:0] obs_occ;
    logic       obs_ready;
    logic       obs_err;

    typedef struct {
        logic       v;
        logic [2:0] u;
        logic [4:0] d;
        logic       f;
        logic [4:0] g;
        logic       rdy;
        logic [4:0] occ;
        logic       err;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_grant();
        logic [4:0] g;
        g = 5'd0;
`ifdef COMMIT_SEQ_FAST_EN
        if (q.size() > 0 && unit_done[q[0]] && !flush) g = 5'(1 << q[0]);
`else
        if (m_elig && q.size() > 0 && !flush) g = 5'(1 << q[0]);
`endif
        return g;
    endfunction

    task automatic model_reset();
        q.delete();
        m_err  = 1'b0;
        m_elig = 1'b0;
    endtask

    task automatic step(input logic v, input logic [2:0] u, input logic [4:0] d, input logic f);
        logic [4:0] g;
        bit ready_pre;
        bit elig_next;
        @(negedge clk);
        issue_valid = v;
        issue_unit  = u;
        unit_done   = d;
        flush       = f;
        #1;
        g         = model_grant();
        ready_pre = (q.size() != DEPTH);
        obs_grant = commit_grant;
        obs_occ   = occupancy;
        obs_ready = issue_ready;
        obs_err   = err_illegal;
        check("grant", commit_grant, g);
        check("ready", issue_ready, ready_pre);
        check("occupancy", occupancy, 8'(q.size()));
        check("err_illegal", err_illegal, m_err);
        $display("t=%0t v=%0b u=%0d d=%05b f=%0b | grant=%05b occ=%0d rdy=%0b err=%0b",
                 $time, v, u, d, f, commit_grant, occupancy, issue_ready, err_illegal);
        elig_next = (q.size() > 0) && d[q[0]] && (g == 5'd0) && !f;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (g != 5'd0) void'(q.pop_front());
            if (v && ready_pre && u <= 3'd4) q.push_back(int'(u));
        end
        if (v && ready_pre && u > 3'd4) m_err = 1'b1;
        m_elig = elig_next;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
        unit_done   = 5'd0;
        #1;
        check("rst_grant", commit_grant, 5'd0);
        check("rst_ready", issue_ready, 1'b1);
        check("rst_occ", occupancy, 5'd0);
        check("rst_err", err_illegal, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int issued[$];
        int granted[$];
        int n_issued;
        logic [4:0] occ_before;
        bit pending;
        logic [2:0] ru;

        // Order scenario: issue 3,0,4; 0 and 4 done early; grants must wait for unit 3.
        tbl[0]  = '{1'b1, 3'd3, 5'b00000, 1'b0, 5'b00000, 1'b1, 5'd0, 1'b0};
        tbl[1]  = '{1'b1, 3'd0, 5'b10001, 1'b0, 5'b00000, 1'b1, 5'd1, 1'b0};
        tbl[2]  = '{1'b1, 3'd4, 5'b10001, 1'b0, 5'b00000, 1'b1, 5'd2, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 5'b10001, 1'b0, 5'b00000, 1'b1, 5'd3, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 5'b10001, 1'b0, 5'b00000, 1'b1, 5'd3, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 5'b11001, 1'b0, 5'b00000, 1'b1, 5'd3, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 5'b11001, 1'b0, 5'b01000, 1'b1, 5'd3, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 5'b11001, 1'b0, 5'b00000, 1'b1, 5'd2, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 5'b11001, 1'b0, 5'b00001, 1'b1, 5'd2, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 5'b11001, 1'b0, 5'b00000, 1'b1, 5'd1, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 5'b11001, 1'b0, 5'b10000, 1'b1, 5'd1, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 5'b00000, 1'b0, 5'b00000, 1'b1, 5'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].u, tbl[i].d, tbl[i].f);
`ifndef COMMIT_SEQ_FAST_EN
            check($sformatf("tbl%0d_grant", i), obs_grant, tbl[i].g);
            check($sformatf("tbl%0d_occ", i), obs_occ, tbl[i].occ);
            check($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_err", i), obs_err, tbl[i].err);
`endif
        end

        // Full table: 8 issues, 9th ignored, one commit frees a slot.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'd1, 5'd0, 1'b0);
        step(1'b1, 3'd2, 5'd0, 1'b0);
        check("full_occ", obs_occ, 5'd8);
        check("full_ready", obs_ready, 1'b0);
        step(1'b0, 3'd0, 5'd0, 1'b0);
        check("full_9th_ignored", obs_occ, 5'd8);
        pending = 1'b1;
        for (int i = 0; i < 3 && pending; i++) begin
            step(1'b0, 3'd0, 5'b00010, 1'b0);
            if (obs_grant != 5'd0) pending = 1'b0;
        end
        check("full_commit_seen", pending, 1'b0);
        check("full_commit_id", obs_grant, 5'b00010);
        step(1'b0, 3'd0, 5'd0, 1'b0);
        check("full_after_occ", obs_occ, 5'd7);
        check("full_after_ready", obs_ready, 1'b1);

        // Illegal ID: no push, sticky error survives flush.
        do_reset();
        step(1'b1, 3'd2, 5'd0, 1'b0);
        step(1'b1, 3'd6, 5'd0, 1'b0);
        check("ill_occ_before", obs_occ, 5'd1);
        step(1'b0, 3'd0, 5'd0, 1'b0);
        check("ill_occ_after", obs_occ, 5'd1);
        check("ill_err_set", obs_err, 1'b1);
        step(1'b0, 3'd0, 5'd0, 1'b1);
        step(1'b0, 3'd0, 5'd0, 1'b0);
        check("ill_err_after_flush", obs_err, 1'b1);
        check("ill_occ_flushed", obs_occ, 5'd0);

        // Flush while the head is done: no grant in the flush cycle, table emptied.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 3'd2, 5'd0, 1'b0);
        step(1'b0, 3'd0, 5'b00100, 1'b0);
        step(1'b1, 3'd3, 5'b00100, 1'b1);
        check("flush_grant", obs_grant, 5'd0);
        step(1'b0, 3'd0, 5'd0, 1'b0);
        check("flush_occ", obs_occ, 5'd0);
        check("flush_ready", obs_ready, 1'b1);

        // Done-to-grant latency on head unit 1.
        do_reset();
        step(1'b1, 3'd1, 5'd0, 1'b0);
        step(1'b0, 3'd0, 5'd0, 1'b0);
        step(1'b0, 3'd0, 5'b00010, 1'b0);
`ifdef COMMIT_SEQ_FAST_EN
        check("lat_cycle_n", obs_grant, 5'b00010);
`else
        check("lat_cycle_n", obs_grant, 5'b00000);
        step(1'b0, 3'd0, 5'b00010, 1'b0);
        check("lat_cycle_n1", obs_grant, 5'b00010);
`endif

        // Simultaneous push and pop keeps occupancy constant.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 5'd0, 1'b0);
        pending = 1'b0;
        occ_before = 5'd0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'd1, 5'b00010, 1'b0);
            if (pending) check("pushpop_occ", obs_occ, occ_before);
            pending    = (obs_grant != 5'd0);
            occ_before = obs_occ;
        end

        // Reset asserted while a grant is live.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 5'd0, 1'b0);
`ifndef COMMIT_SEQ_FAST_EN
        step(1'b0, 3'd0, 5'b00100, 1'b0);
`endif
        @(negedge clk);
        issue_valid = 1'b0;
        flush       = 1'b0;
        unit_done   = 5'b00100;
        #1;
        check("midrst_pre_grant", commit_grant, 5'b00100);
        rst_n = 1'b0;
        #1;
        check("midrst_grant", commit_grant, 5'd0);
        check("midrst_occ", occupancy, 5'd0);
        check("midrst_ready", issue_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 5'b00100, 1'b0);
        check("midrst_after_occ", obs_occ, 5'd0);

        // Wrap: 20 issue/commit pairs through the table, grants in issue order.
        do_reset();
        n_issued = 0;
        for (int c = 0; c < 200 && granted.size() < 20; c++) begin
            ru = 3'($urandom_range(0, 4));
            if (n_issued < 20 && q.size() < DEPTH) begin
                step(1'b1, ru, 5'b11111, 1'b0);
                issued.push_back(int'(ru));
                n_issued++;
            end else begin
                step(1'b0, 3'd0, 5'b11111, 1'b0);
            end
            if (obs_grant != 5'd0) begin
                for (int b = 0; b < 5; b++) if (obs_grant[b]) granted.push_back(b);
            end
            check("wrap_occ_bound", 8'(obs_occ <= 5'd8), 8'd1);
        end
        check("wrap_count", 8'(granted.size()), 8'd20);
        for (int i = 0; i < granted.size() && i < issued.size(); i++) begin
            check($sformatf("wrap_order%0d", i), 8'(granted[i]), 8'(issued[i]));
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            step(1'b1 & ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                 5'($urandom),
                 ($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/commit_sequencer.md
COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

Interface
REQ-001 SHALL have parameter: DEPTH, 8, issue-order table entries (power of 2, 2..16).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: issue_valid  input  1  issue stage records one instruction this cycle.
REQ-005 SHALL have port: issue_unit  input  3  unit ID: 0 alu1, 1 alu2, 2 advint, 3 memunit, 4 branch; 5-7 illegal.
REQ-006 SHALL have port: issue_ready  output  1  table not full.
REQ-007 SHALL have port: unit_done  input  5  per-unit level; bit n high while unit n holds an uncommitted result.
REQ-008 SHALL have port: commit_grant  output  5  one-hot; bit n permits unit n to write the register file this cycle.
REQ-009 SHALL have port: flush  input  1  discard all table entries.
REQ-010 SHALL have port: occupancy  output  5  valid entry count, 0..DEPTH.
REQ-011 SHALL have port: err_illegal  output  1  sticky illegal-ID flag.

Function
REQ-012 SHALL hold unit IDs in a circular FIFO (rd_ptr, wr_ptr, count); pointers wrap DEPTH-1 -> 0.
REQ-013 SHALL push issue_unit when issue_valid & issue_ready & issue_unit<=4; pushed entry becomes head-eligible the following cycle.
REQ-014 SHALL drive issue_ready = (count != DEPTH); issue_valid while full is ignored, no state change.
REQ-015 SHALL not push an illegal ID; SHALL set err_illegal on the next edge.
REQ-016 SHALL grant only the head entry, only when count>0 and unit_done[head] is high; at most one grant bit high per cycle.
REQ-017 SHALL pop the head on the rising edge ending each cycle in which commit_grant is nonzero.
REQ-018 SHALL keep count unchanged on simultaneous push and pop; push into full table with same-cycle pop is still rejected (issue_ready low).
REQ-019 SHALL, in registered mode, use states EMPTY (count==0), WAIT (head not done), GRANT (commit_grant = one-hot of head, exactly one cycle).
REQ-020 SHALL transition EMPTY->WAIT on push; WAIT->GRANT the cycle after unit_done[head] sampled high; GRANT->EMPTY if count becomes 0, else WAIT.
REQ-021 SHALL, in registered mode, yield done-to-grant latency 1 cycle and max throughput 1 commit per 2 cycles.
REQ-022 SHALL ignore unit_done bits of non-head units (no out-of-order commit).
REQ-023 SHALL give flush priority over push and pop: force commit_grant to 0 in the flush cycle, suppress pop, zero count and both pointers at the edge, enter EMPTY.
REQ-024 SHALL drive occupancy = count; err_illegal unaffected by flush.

Reset
REQ-025 SHALL on rst_n low asynchronously clear rd_ptr, wr_ptr, count, all entries to 0, state to EMPTY, err_illegal to 0.
REQ-026 SHALL during and immediately after reset output commit_grant=0, issue_ready=1, occupancy=0, err_illegal=0.
REQ-027 SHALL abandon any in-flight grant when reset asserts mid-operation; no pop recorded.

Configuration
REQ-028 SHALL support macro COMMIT_SEQ_FAST_EN.
REQ-029 SHALL, with COMMIT_SEQ_FAST_EN defined, drive commit_grant combinationally = one-hot(head) & unit_done & (count>0) & ~flush: 0-cycle latency, 1 commit per cycle, no GRANT state.
REQ-030 SHALL, with COMMIT_SEQ_FAST_EN undefined, use the registered EMPTY/WAIT/GRANT machine of REQ-019..021.

Verification
REQ-031 SHALL verify order: issue 3,0,4; unit_done=5'b10001 held -> no grant until unit 3 done; raising bit3 -> grants 01000,00001,10000 in that order.
REQ-032 SHALL verify full: 8 issues with no done -> occupancy=8, issue_ready=0; 9th issue ignored; one commit -> issue_ready=1, occupancy=7.
REQ-033 SHALL verify wrap: 20 issue/commit pairs through DEPTH=8 -> IDs granted in issue sequence, occupancy never exceeds 8.
REQ-034 SHALL verify illegal: issue_unit=6 -> occupancy unchanged, err_illegal=1 next cycle, remains 1 after flush.
REQ-035 SHALL verify flush: occupancy=5, head done, flush high -> commit_grant=0 that cycle, occupancy=0 next cycle, issue_ready=1.
REQ-036 SHALL verify timing: unit_done[1] rises cycle N on head 1 -> grant cycle N+1 (registered) or cycle N (FAST); simultaneous push/pop keeps occupancy constant.
